// File: rtl/temporal_pkg.sv
// Shared types and defaults for temporal-coding stages (encoders, comparators).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temporal_pkg;

    // Default gamma framing: clocks per gamma cycle and spike high time.
    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;

    // Storage width of a code value; wide enough for any practical gamma cycle.
    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FIRE,
        DONE
    } enc_state_t;

    // One temporal code: is_null suppresses the spike for the whole gamma cycle.
    typedef struct packed {
        logic              is_null;
        logic [CODE_W-1:0] value;
    } temporal_code_t;

endpackage

// File: rtl/gamma_counter.sv
// Free-running gamma-cycle counter producing the gamma reset and a wrap strobe.
// Latency: outputs decode the registered count only (no input-to-output path).
// Backpressure: none; runs every clock, restarts at 0 on reset.
// Ports: aclk/rst (sync, active-high); gcnt = position in cycle;
//        grst = high when gcnt==0; wrap = high when the next edge returns to 0.
module gamma_counter
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int CNT_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic             aclk,
    input  logic             rst,
    output logic [CNT_W-1:0] gcnt,
    output logic             grst,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);

    logic [CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0] gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q + CNT_W'(1);
        if (gcnt_q == LAST) begin
            gcnt_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign gcnt = gcnt_q;
    assign grst = (gcnt_q == '0);
    assign wrap = (gcnt_q == LAST);

endmodule

// File: rtl/pulse_width_encoder.sv
// Encodes binary values as fixed-width spikes whose start offset within the gamma cycle carries the value.
// Latency: a code accepted on the wrap cycle spikes v+2 clocks later; earlier codes wait for the next wrap.
// Backpressure: one-entry pending register; in_ready drops while it is full, until the next wrap frees it.
// Ports: aclk/rst (sync, active-high); in_valid/in_ready/in_value/in_null = code handshake;
//        grst = gamma reset (one clock at cycle start); spike = pulse-width-coded output.
// Build option: define PWE_SATURATE_EN to clamp out-of-range values to MAX_CODE instead of nulling them.
module pulse_width_encoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    input  logic             in_null,
    output logic             grst,
    output logic             spike
);

    localparam int CNT_W    = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int MAX_CODE = GAMMA_CYCLE_WIDTH - PULSE_WIDTH - 1;

    localparam logic [CODE_W-1:0] MAX_CODE_C = CODE_W'(MAX_CODE);
    localparam logic [CODE_W-1:0] PW_C       = CODE_W'(PULSE_WIDTH);

    logic [CNT_W-1:0]  gcnt;
    logic              wrap;
    logic [CODE_W-1:0] gcnt_ext;
    logic              xfer;
    temporal_code_t    in_code;

    enc_state_t        state_q, state_d;
    temporal_code_t    act_q, act_d;
    temporal_code_t    pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .CNT_W             (CNT_W)
    ) u_gamma_counter (
        .aclk (aclk),
        .rst  (rst),
        .gcnt (gcnt),
        .grst (grst),
        .wrap (wrap)
    );

    assign gcnt_ext = CODE_W'(gcnt);
    assign in_ready = !pend_valid_q && !rst;
    assign xfer     = in_valid && in_ready;

    // Range handling happens once, at acceptance, so the FSM only ever sees
    // values whose pulse fits before the wrap.
    always_comb begin
        in_code         = '0;
        in_code.is_null = in_null;
        in_code.value   = CODE_W'(in_value);
        if (in_null) begin
            in_code.value = '0;
        end else if (CODE_W'(in_value) > MAX_CODE_C) begin
`ifdef PWE_SATURATE_EN
            in_code.value = MAX_CODE_C;
`else
            in_code.is_null = 1'b1;
            in_code.value   = '0;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (wrap) begin
            // Promotion: pending wins; an empty pending lets a same-cycle
            // transfer bypass straight to active.
            if (pend_valid_q) begin
                act_d        = pend_q;
                pend_valid_d = 1'b0;
            end else if (xfer) begin
                act_d = in_code;
            end else begin
                act_d.is_null = 1'b1;
                act_d.value   = '0;
            end
            state_d = act_d.is_null ? IDLE : WAIT;
        end else begin
            if (xfer) begin
                pend_d       = in_code;
                pend_valid_d = 1'b1;
            end
            unique case (state_q)
                WAIT: begin
                    if (gcnt_ext == act_q.value) begin
                        state_d = FIRE;
                    end
                end
                FIRE: begin
                    // Last high cycle is gcnt == v+PULSE_WIDTH.
                    if (gcnt_ext == act_q.value + PW_C) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q        <= IDLE;
            act_q.is_null  <= 1'b1;
            act_q.value    <= '0;
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign spike = (state_q == FIRE);

endmodule

// File: doc/pulse_width_encoder.md
# pulse_width_encoder

Converts binary values into pulse-width-coded spikes aligned to a free-running gamma cycle, and generates the gamma reset that frames each cycle. Sits directly upstream of the temporal comparison primitives (less_than_eq and peers): its `spike` drives their `a`/`b` inputs, and its `grst` drives their `grst`. A one-entry holding register lets the producer load the next gamma cycle's value while the current spike is being emitted.

## Interface
- `GAMMA_CYCLE_WIDTH`, default 16: clocks per gamma cycle; must be ≥ `PULSE_WIDTH`+2.
- `PULSE_WIDTH`, default 8: spike high time in clocks.
- `VAL_W`, default `$clog2(GAMMA_CYCLE_WIDTH)`: width of `in_value`.
- Derived constant `MAX_CODE` = `GAMMA_CYCLE_WIDTH`-`PULSE_WIDTH`-1 (7 at defaults).

Ports:
- `aclk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: producer offers a code.
- `in_ready` output 1: encoder can accept a code.
- `in_value` input `VAL_W`: spike start offset.
- `in_null` input 1: code carries no spike.
- `grst` output 1: gamma reset, high for one clock at gamma cycle start.
- `spike` output 1: pulse-width-coded output.

## Operation
- Gamma counter `gcnt` runs 0..`GAMMA_CYCLE_WIDTH`-1 and wraps to 0. `grst` = (`gcnt`==0).
- Handshake: transfer occurs when `in_valid`&&`in_ready`. `in_ready` = !`pend_valid` && !`rst`. Accepted code {null, value} goes to the pending register.
- Promotion happens at the edge where `gcnt` goes from `GAMMA_CYCLE_WIDTH`-1 to 0:
  - The active code is loaded from pending if `pend_valid`, and `pend_valid` is cleared.
  - If pending is empty but a transfer occurs in that same cycle, the incoming code goes straight to active.
  - Otherwise active becomes null.
- Active FSM, re-entered every gamma cycle:
  - IDLE: null code; `spike`=0 all cycle.
  - WAIT: `gcnt` ≤ v.
  - FIRE: `gcnt` in [v+1, v+`PULSE_WIDTH`]; `spike`=1.
  - DONE: after the pulse, until wrap.
  - Transitions: wrap → IDLE or WAIT per the new code; WAIT→FIRE at `gcnt`==v; FIRE→DONE after `PULSE_WIDTH` clocks.
- Range: v in 0..`MAX_CODE` spikes. Spike never overlaps `grst`, and the last high cycle is at most `gcnt`=`GAMMA_CYCLE_WIDTH`-1. Out-of-range handling is set under Configuration.
- `in_null`=1 always yields IDLE, regardless of `in_value`.
- Reset (any time, including mid-spike): at the next edge `gcnt`=0, FSM=IDLE, pending cleared. Codes offered while `rst`=1 are not accepted.

## Timing
- Reset values: `grst`=1 (`gcnt`=0), `spike`=0, `in_ready`=0 while `rst`=1 and 1 in the first cycle after release.
- All outputs decode only registered state. There is no combinational input→output path except `rst`→`in_ready`.
- Spike rising edge at `gcnt`=v+1, falling edge after `gcnt`=v+`PULSE_WIDTH`.
- Latency: a code accepted at `gcnt`==`GAMMA_CYCLE_WIDTH`-1 has its spike rise v+2 clocks later. A code accepted earlier waits for the next wrap.
- Throughput: one code per gamma cycle. A second offer stalls (`in_ready`=0) until promotion frees pending.

## Configuration
- `PWE_SATURATE_EN`:
  - Defined: a non-null `in_value` > `MAX_CODE` is clamped to `MAX_CODE` at acceptance.
  - Undefined: such a value is converted to null at acceptance (no spike that cycle).

## Structure
- Shared package `temporal_pkg` holds:
  - Default `GAMMA_CYCLE_WIDTH`/`PULSE_WIDTH` constants.
  - `enc_state_t` enum {IDLE, WAIT, FIRE, DONE}.
  - `temporal_code_t` packed struct {null, value}.
- Sub-module `gamma_counter` provides `gcnt`, `grst` and a `wrap` strobe. It is reusable by other temporal stages.

## Test plan
- Reset release, no codes → `grst` high exactly every 16 clocks starting at the first post-reset cycle; `spike` stays 0.
- Offer v=3 at `gcnt`=15 → accepted that cycle; in the next gamma cycle `spike`=1 for `gcnt` 4..11, 0 elsewhere.
- Offer v=0 then v=7 back-to-back → second offer stalls (`in_ready`=0) until wrap; spikes cover `gcnt` 1..8 and then 8..15 in consecutive gamma cycles.
- Offer v=12 → with `PWE_SATURATE_EN`, spike covers `gcnt` 8..15; without it, no spike; `in_null`=1 with v=2 → no spike.
- Assert `rst` at `gcnt`=6 during a v=3 spike → `spike`=0 and `grst`=1 on the next edge; pending code discarded; no spike in the following gamma cycle.
- Drive two encoders into less_than_eq with a: v=2, b: v=5 → q asserts; then swap the values → q stays low.
